// File: rtl/lattice_pkg.sv
// lattice_pkg
// Shared constants for the lattice_scroll LED-matrix driver:
//   - mode encoding for the scroll/blink selector
//   - default 8-row, 16-bit-wide glyphs loaded into pattern memory at reset
//     (red = vacant glyph, green = occupied glyph)
//   - glyph_row(): extracts one 16-bit row from a packed glyph constant
package lattice_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_STATIC = 2'b00;
    localparam mode_t MODE_LEFT   = 2'b01;
    localparam mode_t MODE_RIGHT  = 2'b10;
    localparam mode_t MODE_BLINK  = 2'b11;

    localparam int GLYPH_ROWS = 8;
    localparam int GLYPH_W    = 16;

    // Packed glyphs: row r occupies bits [16*r +: 16], so row 0 is the last
    // entry of each concatenation.
    localparam logic [GLYPH_ROWS*GLYPH_W-1:0] GLYPH_VACANT = {
        16'h8181, 16'h4242, 16'h2424, 16'h1818,
        16'h1818, 16'h2424, 16'h4242, 16'h8181
    };

    localparam logic [GLYPH_ROWS*GLYPH_W-1:0] GLYPH_OCCUPIED = {
        16'h3C3C, 16'h4242, 16'h8181, 16'h8181,
        16'h8181, 16'h8181, 16'h4242, 16'h3C3C
    };

    function automatic logic [GLYPH_W-1:0] glyph_row(
        input logic [GLYPH_ROWS*GLYPH_W-1:0] glyph,
        input logic [2:0]                    r
    );
        return glyph[{r, 4'b0000} +: GLYPH_W];
    endfunction

endpackage

// File: rtl/lattice_scan.sv
// lattice_scan
// Row-scan timebase: a prescaler counting 0..SCAN_DIV-1 and a row index
// counting 0..ROWS-1 that advances on every prescaler wrap.
// Ports:
//   clk, rst    - system clock, asynchronous active-high reset
//   row         - current row index
//   slot_start  - high on the first cycle of every row slot (prescaler = 0)
//   frame_tick  - high on the last cycle of row ROWS-1
module lattice_scan #(
    parameter  int ROWS     = 8,
    parameter  int SCAN_DIV = 1000,
    localparam int ROW_W    = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    output logic [ROW_W-1:0] row,
    output logic             slot_start,
    output logic             frame_tick
);

    localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

    logic [PRE_W-1:0] presc;
    logic             presc_wrap;

    assign presc_wrap = (presc == PRE_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
            row   <= '0;
        end else if (presc_wrap) begin
            presc <= '0;
            row   <= (row == ROW_LAST) ? '0 : row + ROW_W'(1);
        end else begin
            presc <= presc + PRE_W'(1);
        end
    end

    assign slot_start = (presc == '0);
    // Decoded straight from the counters so it lines up exactly with the
    // last cycle of the frame and clears with them on reset.
    assign frame_tick = presc_wrap && (row == ROW_LAST);

endmodule

// File: rtl/lattice_scroll.sv
// lattice_scroll
// Bicolour LED-matrix driver: scans ROWS rows, shows a COLS-wide circular
// window of a PAT_W-bit pattern row on either the red or green columns, and
// scrolls left/right or blinks once every STEP_FRAMES frames.
// Ports:
//   clk, rst           - system clock, asynchronous active-high reset
//   onride             - 1 = green (occupied) pattern, 0 = red (vacant)
//   mode               - 00 static, 01 scroll left, 10 scroll right, 11 blink
//   pause              - freezes scroll offset and blink phase
//   wr_en/wr_ch/wr_row/wr_data - pattern memory write port (ch 0 red, 1 green)
//   row_sel            - one-hot active row
//   col_r, col_g       - red / green column drive
//   frame_tick         - one-cycle pulse on the last cycle of row ROWS-1
module lattice_scroll
    import lattice_pkg::*;
#(
    parameter  int ROWS        = 8,
    parameter  int COLS        = 8,
    parameter  int PAT_W       = 32,
    parameter  int SCAN_DIV    = 1000,
    parameter  int STEP_FRAMES = 16,
    localparam int ROW_W       = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             onride,
    input  logic [1:0]       mode,
    input  logic             pause,
    input  logic             wr_en,
    input  logic             wr_ch,
    input  logic [ROW_W-1:0] wr_row,
    input  logic [PAT_W-1:0] wr_data,
    output logic [ROWS-1:0]  row_sel,
    output logic [COLS-1:0]  col_r,
    output logic [COLS-1:0]  col_g,
    output logic             frame_tick
);

    localparam int OFF_W  = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam int STEP_W = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
    localparam int REP    = PAT_W / GLYPH_W + 1;

    localparam logic [OFF_W-1:0]  OFF_LAST  = OFF_W'(PAT_W - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_FRAMES - 1);

    // Repeat a 16-bit glyph row across the full pattern width.
    function automatic logic [PAT_W-1:0] tile(input logic [GLYPH_W-1:0] g);
        logic [REP*GLYPH_W-1:0] rep;
        rep = {REP{g}};
        return rep[PAT_W-1:0];
    endfunction

    // Circular COLS-wide window starting at bit 'off'; bit 'off' -> column 0.
    function automatic logic [COLS-1:0] window(
        input logic [PAT_W-1:0] pat,
        input logic [OFF_W-1:0] off
    );
        logic [COLS-1:0] w;
        logic [OFF_W:0]  idx;
        w = '0;
        for (int c = 0; c < COLS; c++) begin
            idx = {1'b0, off} + (OFF_W+1)'(c);
            if (idx >= (OFF_W+1)'(PAT_W))
                idx = idx - (OFF_W+1)'(PAT_W);
            w[c] = pat[idx[OFF_W-1:0]];
        end
        return w;
    endfunction

    logic [ROW_W-1:0]  scan_row;
    logic              slot_start;

    lattice_scan #(
        .ROWS     (ROWS),
        .SCAN_DIV (SCAN_DIV)
    ) u_scan (
        .clk        (clk),
        .rst        (rst),
        .row        (scan_row),
        .slot_start (slot_start),
        .frame_tick (frame_tick)
    );

    // ---- frame-boundary state: sampled onride/mode, step counter, offset, blink
    logic              on_s;
    mode_t             mode_s;
    logic [STEP_W-1:0] step_cnt;
    logic [OFF_W-1:0]  offset;
    logic              blink;
    logic              changed;
    logic              step_evt;

    assign changed  = (onride != on_s) || (mode != mode_s);
    assign step_evt = frame_tick && !pause && (step_cnt == STEP_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            on_s     <= 1'b0;
            mode_s   <= MODE_STATIC;
            step_cnt <= '0;
            offset   <= '0;
            blink    <= 1'b0;
        end else if (frame_tick) begin
            on_s   <= onride;
            mode_s <= mode;
            if (!pause)
                step_cnt <= step_evt ? '0 : step_cnt + STEP_W'(1);
            // A channel/mode change restarts the animation from offset 0,
            // which takes priority over a step landing on the same boundary.
            if (changed) begin
                offset <= '0;
                blink  <= 1'b0;
            end else if (step_evt) begin
                case (mode_s)
                    MODE_LEFT:  offset <= (offset == OFF_LAST) ? '0 : offset + OFF_W'(1);
                    MODE_RIGHT: offset <= (offset == '0) ? OFF_LAST : offset - OFF_W'(1);
                    MODE_BLINK: blink  <= ~blink;
                    default:    ;
                endcase
            end
        end
    end

    // ---- pattern memory, reset to the tiled default glyphs
    logic [PAT_W-1:0] red_mem [ROWS];
    logic [PAT_W-1:0] grn_mem [ROWS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < ROWS; r++) begin
                red_mem[r] <= tile(glyph_row(GLYPH_VACANT, 3'(r)));
                grn_mem[r] <= tile(glyph_row(GLYPH_OCCUPIED, 3'(r)));
            end
        end else if (wr_en && (int'(wr_row) < ROWS)) begin
            if (wr_ch)
                grn_mem[wr_row] <= wr_data;
            else
                red_mem[wr_row] <= wr_data;
        end
    end

    // ---- output stage: latched once per row slot so a mid-slot write or
    // state change never disturbs the row currently being shown
    logic [PAT_W-1:0] sel_pat;
    logic [COLS-1:0]  win;
    logic             blank;

    always_comb begin
        sel_pat = on_s ? grn_mem[scan_row] : red_mem[scan_row];
        win     = window(sel_pat, offset);
        blank   = (mode_s == MODE_BLINK) && blink;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_sel <= ROWS'(1);
            col_r   <= '0;
            col_g   <= '0;
        end else if (slot_start) begin
            row_sel <= ROWS'(1) << scan_row;
            col_g   <= (on_s && !blank)  ? win : '0;
            col_r   <= (!on_s && !blank) ? win : '0;
        end
    end

endmodule

// File: tb/tb_lattice_scroll.sv
module tb_lattice_scroll;

    localparam int ROWS        = 8;
    localparam int COLS        = 8;
    localparam int PAT_W       = 32;
    localparam int SCAN_DIV    = 4;
    localparam int STEP_FRAMES = 2;
    localparam int FRAME       = ROWS * SCAN_DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        onride = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic        pause = 1'b0;
    logic        wr_en = 1'b0;
    logic        wr_ch = 1'b0;
    logic [2:0]  wr_row = '0;
    logic [31:0] wr_data = '0;
    logic [7:0]  row_sel;
    logic [7:0]  col_r;
    logic [7:0]  col_g;
    logic        frame_tick;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    lattice_scroll #(
        .ROWS        (ROWS),
        .COLS        (COLS),
        .PAT_W       (PAT_W),
        .SCAN_DIV    (SCAN_DIV),
        .STEP_FRAMES (STEP_FRAMES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .onride     (onride),
        .mode       (mode),
        .pause      (pause),
        .wr_en      (wr_en),
        .wr_ch      (wr_ch),
        .wr_row     (wr_row),
        .wr_data    (wr_data),
        .row_sel    (row_sel),
        .col_r      (col_r),
        .col_g      (col_g),
        .frame_tick (frame_tick)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // k = clock edges since reset release. Each row slot shows the picture
    // described by the model state at the slot's first cycle; frame ends
    // apply the sampling / step rules.
    logic [15:0] vac [8];
    logic [15:0] occ [8];
    logic [31:0] m_red [8];
    logic [31:0] m_grn [8];
    int          k, run_frames, m_off, mr;
    logic        m_on, m_blink, m_step;
    logic [1:0]  m_mode;
    logic [7:0]  e_sel, e_r, e_g, vis;
    logic [31:0] m_pat;

    always @(negedge clk) begin
        if (rst) begin
            vac = '{16'h8181, 16'h4242, 16'h2424, 16'h1818, 16'h1818, 16'h2424, 16'h4242, 16'h8181};
            occ = '{16'h3C3C, 16'h4242, 16'h8181, 16'h8181, 16'h8181, 16'h8181, 16'h4242, 16'h3C3C};
            for (int r = 0; r < ROWS; r++) begin
                m_red[r] = {2{vac[r]}};
                m_grn[r] = {2{occ[r]}};
            end
            k = 0; run_frames = 0; m_off = 0;
            m_on = 1'b0; m_blink = 1'b0; m_mode = 2'b00;
            e_sel = 8'h01; e_r = 8'h00; e_g = 8'h00;
            check("rst_row_sel", row_sel, 8'h01);
            check("rst_col_r", col_r, 8'h00);
            check("rst_col_g", col_g, 8'h00);
            check("rst_frame_tick", frame_tick, 1'b0);
        end else begin
            check("row_sel", row_sel, e_sel);
            check("col_r", col_r, e_r);
            check("col_g", col_g, e_g);
            check("frame_tick", frame_tick, (k % FRAME) == FRAME - 1);
            if (k % SCAN_DIV == 0) begin
                mr    = (k / SCAN_DIV) % ROWS;
                e_sel = 8'(1 << mr);
                m_pat = m_on ? m_grn[mr] : m_red[mr];
                for (int c = 0; c < COLS; c++)
                    vis[c] = m_pat[(m_off + c) % PAT_W];
                if (m_mode == 2'b11 && m_blink)
                    vis = 8'h00;
                e_g = m_on ? vis : 8'h00;
                e_r = m_on ? 8'h00 : vis;
            end
            if (k % FRAME == FRAME - 1) begin
                m_step = 1'b0;
                if (!pause) begin
                    run_frames++;
                    m_step = (run_frames % STEP_FRAMES) == 0;
                end
                if (onride != m_on || mode != m_mode) begin
                    m_on = onride; m_mode = mode; m_off = 0; m_blink = 1'b0;
                end else if (m_step) begin
                    if (m_mode == 2'b01) m_off = (m_off + 1) % PAT_W;
                    if (m_mode == 2'b10) m_off = (m_off + PAT_W - 1) % PAT_W;
                    if (m_mode == 2'b11) m_blink = ~m_blink;
                end
            end
            if (wr_en && int'(wr_row) < ROWS) begin
                if (wr_ch) m_grn[wr_row] = wr_data;
                else       m_red[wr_row] = wr_data;
            end
            k++;
        end
    end

    // ---------------- directed stimulus ----------------
    // Wait for n frame_ticks, then land on the second cycle of the next
    // frame, where row 0 of the new frame is on the outputs.
    task automatic tick_to(input int n);
        for (int i = 0; i < n; i++) begin
            int w;
            w = 0;
            do begin
                @(negedge clk);
                w++;
            end while (frame_tick !== 1'b1 && w < 100);
            check("frame_tick_wait", frame_tick, 1'b1);
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic write(input logic ch, input logic [2:0] r, input logic [31:0] d);
        @(posedge clk); #2;
        wr_en = 1'b1; wr_ch = ch; wr_row = r; wr_data = d;
        @(posedge clk); #2;
        wr_en = 1'b0;
    endtask

    task automatic restart(input logic on, input logic [1:0] md);
        @(posedge clk); #2;
        rst = 1'b1; onride = on; mode = md; pause = 1'b0;
        @(posedge clk); #2;
        rst = 1'b0;
    endtask

    initial begin
        // Reset release and first row slots (default vacant glyph, red)
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("lit_reset_row_sel", row_sel, 8'h01);
        check("lit_reset_cols", {col_r, col_g}, 16'h0000);
        @(negedge clk);
        check("lit_red_row0_default", col_r, 8'h81);
        check("lit_green_off", col_g, 8'h00);
        repeat (4) @(negedge clk);
        check("lit_row1_sel", row_sel, 8'h02);
        check("lit_red_row1_default", col_r, 8'h42);

        // Static green with a written row 0
        @(posedge clk); #2 onride = 1'b1;
        write(1'b1, 3'd0, 32'h1320_1320);
        tick_to(1);
        check("lit_static_row_sel", row_sel, 8'h01);
        check("lit_static_col_g", col_g, 8'h20);
        check("lit_static_col_r", col_r, 8'h00);

        // onride toggled mid-frame; green write to row 3 mid-slot
        repeat (10) @(posedge clk);
        #2 onride = 1'b0;
        @(negedge clk);
        check("lit_midframe_still_green", col_g, 8'h81);
        check("lit_midframe_red_off", col_r, 8'h00);
        repeat (3) @(negedge clk);
        check("lit_row3_sel", row_sel, 8'h08);
        write(1'b1, 3'd3, 32'h0000_000F);
        @(negedge clk);
        check("lit_row3_write_not_midslot", col_g, 8'h81);
        tick_to(1);
        check("lit_switch_red_row0", col_r, 8'h81);
        check("lit_switch_green_off", col_g, 8'h00);
        repeat (13) @(negedge clk);
        check("lit_switch_red_row3", col_r, 8'h18);

        // Scroll left, wrap after 64 frames
        restart(1'b1, 2'b01);
        write(1'b1, 3'd0, 32'h0000_0001);
        tick_to(1);
        check("lit_left_f1", col_g, 8'h01);
        tick_to(1);
        check("lit_left_f2", col_g, 8'h00);
        tick_to(60);
        check("lit_left_f62", col_g, 8'h02);
        tick_to(2);
        check("lit_left_f64_wrap", col_g, 8'h01);

        // Scroll right from reset
        restart(1'b1, 2'b10);
        write(1'b1, 3'd0, 32'h0000_0001);
        tick_to(1);
        check("lit_right_f1", col_g, 8'h01);
        tick_to(1);
        check("lit_right_f2", col_g, 8'h02);

        // Blink with pause
        restart(1'b1, 2'b11);
        tick_to(1);
        check("lit_blink_on", col_g, 8'h3C);
        tick_to(1);
        check("lit_blink_off", {col_r, col_g}, 16'h0000);
        tick_to(1);
        check("lit_blink_off_hold", col_g, 8'h00);
        tick_to(1);
        check("lit_blink_on_again", col_g, 8'h3C);
        tick_to(2);
        check("lit_blink_off2", col_g, 8'h00);
        @(posedge clk); #2 pause = 1'b1;
        tick_to(3);
        check("lit_pause_hold_blank", {col_r, col_g}, 16'h0000);
        check("lit_pause_row_scan", row_sel, 8'h01);
        @(posedge clk); #2 pause = 1'b0;
        tick_to(2);
        check("lit_unpause_on", col_g, 8'h3C);

        // Asynchronous reset mid-frame
        repeat (7) @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        check("lit_async_rst_row_sel", row_sel, 8'h01);
        check("lit_async_rst_cols", {col_r, col_g}, 16'h0000);
        @(posedge clk); #2 rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("lit_after_rst_row_sel", row_sel, 8'h01);
        check("lit_after_rst_red", col_r, 8'h81);

        repeat (40) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

endmodule
